// File: rtl/gray_to_binary_tracker_pkg.sv
// Shared types and helpers for the Gray-code receive tracker.
// Holds the tracker FSM states and a width-agnostic Gray-to-binary decoder.
package gray_to_binary_tracker_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    ACQ     = 2'd0,
    TRACK   = 2'd1,
    CONFIRM = 2'd2
  } trk_state_e;

  // Zero-extended codes decode correctly, so one 32-bit routine serves any width up to 32.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_binary_tracker_if.sv
// Bus between a Gray-code source/controller (master) and the tracker (slave).
interface gray_to_binary_tracker_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned POS_W = 16
);
  logic [WIDTH-1:0] gray_in;
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             step_up;
  logic             step_dn;
  logic             jump_err;
  logic [POS_W-1:0] position;

  modport master (
    output gray_in, en, clr,
    input  bin_out, bin_valid, step_up, step_dn, jump_err, position
  );

  modport slave (
    input  gray_in, en, clr,
    output bin_out, bin_valid, step_up, step_dn, jump_err, position
  );
endinterface

// File: rtl/gray_to_binary_tracker_sync_2ff.sv
// Two-flop synchroniser for a multi-bit Gray bus; Gray coding keeps the sampled word coherent.
module gray_to_binary_tracker_sync_2ff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/gray_to_binary_tracker.sv
// Gray-code receive tracker: sync, decode, step/jump detection and signed position count.
// Optional GRAY_TRK_FILTER_EN: a changed code must be seen on two consecutive enabled cycles.
module gray_to_binary_tracker
  import gray_to_binary_tracker_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned POS_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  gray_to_binary_tracker_if.slave   bus_if
);

  logic [WIDTH-1:0] gray_sync_c;
  logic [WIDTH-1:0] dec_c;
  logic [WIDTH-1:0] delta_c;
  logic             up_c;
  logic             dn_c;
  logic             accept_c;

  trk_state_e       state_q;
  logic [WIDTH-1:0] bin_q;
  logic             valid_q;
  logic             step_up_q;
  logic             step_dn_q;
  logic             jump_err_q;
  logic [POS_W-1:0] pos_q;
`ifdef GRAY_TRK_FILTER_EN
  logic [WIDTH-1:0] cand_q;
`endif

  gray_to_binary_tracker_sync_2ff #(.WIDTH(WIDTH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus_if.gray_in),
    .q_o (gray_sync_c)
  );

  assign dec_c   = WIDTH'(gray2bin(GRAY_MAX_W'(gray_sync_c)));
  assign delta_c = dec_c - bin_q;
  assign up_c    = (delta_c == WIDTH'(1));
  assign dn_c    = (delta_c == '1);

  // A new code is committed from TRACK directly, or from CONFIRM once the candidate repeats.
`ifdef GRAY_TRK_FILTER_EN
  assign accept_c = (state_q == CONFIRM) && (dec_c == cand_q);
`else
  assign accept_c = (state_q == TRACK) && (delta_c != '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACQ;
      bin_q      <= '0;
      valid_q    <= 1'b0;
      step_up_q  <= 1'b0;
      step_dn_q  <= 1'b0;
      jump_err_q <= 1'b0;
      pos_q      <= '0;
`ifdef GRAY_TRK_FILTER_EN
      cand_q     <= '0;
`endif
    end else begin
      step_up_q  <= 1'b0;
      step_dn_q  <= 1'b0;
      jump_err_q <= 1'b0;
      if (bus_if.clr) begin
        pos_q   <= '0;
        valid_q <= 1'b0;
        state_q <= ACQ;
`ifdef GRAY_TRK_FILTER_EN
        cand_q  <= '0;
`endif
      end else if (bus_if.en) begin
        if (accept_c) begin
          bin_q      <= dec_c;
          step_up_q  <= up_c;
          step_dn_q  <= dn_c;
          jump_err_q <= !(up_c || dn_c);
          if (up_c) begin
            pos_q <= pos_q + POS_W'(1);
          end else if (dn_c) begin
            pos_q <= pos_q - POS_W'(1);
          end
        end
        case (state_q)
          ACQ: begin
            bin_q   <= dec_c;
            valid_q <= 1'b1;
            state_q <= TRACK;
          end
`ifdef GRAY_TRK_FILTER_EN
          TRACK: begin
            if (delta_c != '0) begin
              cand_q  <= dec_c;
              state_q <= CONFIRM;
            end
          end
          // Commit on a repeat, abandon on a return to the held code, else chase the new code.
          CONFIRM: begin
            if ((dec_c == cand_q) || (dec_c == bin_q)) begin
              state_q <= TRACK;
            end else begin
              cand_q <= dec_c;
            end
          end
`else
          TRACK:   state_q <= TRACK;
`endif
          default: state_q <= ACQ;
        endcase
      end
    end
  end

  assign bus_if.bin_out   = bin_q;
  assign bus_if.bin_valid = valid_q;
  assign bus_if.step_up   = step_up_q;
  assign bus_if.step_dn   = step_dn_q;
  assign bus_if.jump_err  = jump_err_q;
  assign bus_if.position  = pos_q;

endmodule
